// File: rtl/d5m_config_sequencer.sv
// Writes the six-entry D5M sensor start-up register table through an external I2C byte master.
// Build option: define D5M_CFG_RETRY_EN to retry a NACKed entry up to three times.
module d5m_config_sequencer #(
  parameter int         GAP_CC     = 1000,
  parameter int         TIMEOUT_CC = 100000,
  parameter logic [7:0] DEV_ADDR   = 8'hBA
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1Start,
  input  logic [15:0] piul16Exposure,
  output logic        poul1Busy,
  output logic        poul1Done,
  output logic        poul1Error,
  output logic [2:0]  poul3Index,
  output logic        poul1I2cReq,
  output logic [7:0]  poul8I2cDevAddr,
  output logic [7:0]  poul8I2cRegAddr,
  output logic [15:0] poul16I2cData,
  input  logic        piul1I2cAck,
  input  logic        piul1I2cNack
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam logic [2:0] LAST_IDX = 3'd5;

  localparam int GAP_W = (GAP_CC > 1) ? $clog2(GAP_CC) : 1;
  localparam int TMO_W = (TIMEOUT_CC > 1) ? $clog2(TIMEOUT_CC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

  logic [2:0]       state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [2:0]       index_r;
  logic             req_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [7:0]       dev_addr_r;
  logic [7:0]       reg_addr_r;
  logic [15:0]      data_r;

  logic [7:0]       tbl_reg_s;
  logic [15:0]      tbl_data_s;
  logic             idle_like_s;
  logic             retry_ok_s;

  assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR);

  // Register/data pair for the entry selected by the current index.
  always_comb begin
    tbl_reg_s  = 8'h00;
    tbl_data_s = 16'h0000;
    case (index_r)
      3'd0: begin tbl_reg_s = 8'h0D; tbl_data_s = 16'h0001;       end
      3'd1: begin tbl_reg_s = 8'h0D; tbl_data_s = 16'h0000;       end
      3'd2: begin tbl_reg_s = 8'h20; tbl_data_s = 16'hC000;       end
      3'd3: begin tbl_reg_s = 8'h09; tbl_data_s = piul16Exposure; end
      3'd4: begin tbl_reg_s = 8'h05; tbl_data_s = 16'h0000;       end
      3'd5: begin tbl_reg_s = 8'h06; tbl_data_s = 16'h0019;       end
      default: begin tbl_reg_s = 8'h00; tbl_data_s = 16'h0000;    end
    endcase
  end

`ifdef D5M_CFG_RETRY_EN
  logic [1:0] retry_cnt_r;

  assign retry_ok_s = (retry_cnt_r != 2'd3);

  // NACKed attempts of the current entry; cleared on a new sequence or an ACK.
  always_ff @(posedge piul1Clock or posedge piul1Reset) begin
    if (piul1Reset) begin
      retry_cnt_r <= 2'd0;
    end else if (idle_like_s && piul1Start) begin
      retry_cnt_r <= 2'd0;
    end else if (state_r == ST_WAIT && piul1I2cNack) begin
      if (retry_ok_s) begin
        retry_cnt_r <= retry_cnt_r + 2'd1;
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
    end else if (state_r == ST_WAIT && piul1I2cAck) begin
      retry_cnt_r <= 2'd0;
    end else begin
      retry_cnt_r <= retry_cnt_r;
    end
  end
`else
  assign retry_ok_s = 1'b0;
`endif

  // Sequencer FSM; every output is a flop so the I2C fields are glitch-free while Req is high.
  always_ff @(posedge piul1Clock or posedge piul1Reset) begin
    if (piul1Reset) begin
      state_r    <= ST_IDLE;
      gap_cnt_r  <= GAP_ZERO;
      tmo_cnt_r  <= TMO_ZERO;
      index_r    <= 3'd0;
      req_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      dev_addr_r <= 8'h00;
      reg_addr_r <= 8'h00;
      data_r     <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (piul1Start) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= GAP_ZERO;
            index_r   <= 3'd0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            // Exposure is captured here so a late change still lands in this attempt.
            gap_cnt_r  <= GAP_ZERO;
            state_r    <= ST_REQ;
            req_r      <= 1'b1;
            dev_addr_r <= DEV_ADDR;
            reg_addr_r <= tbl_reg_s;
            data_r     <= tbl_data_s;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
          end
        end
        ST_REQ: begin
          state_r   <= ST_WAIT;
          tmo_cnt_r <= TMO_ZERO;
        end
        ST_WAIT: begin
          if (piul1I2cNack) begin
            req_r <= 1'b0;
            if (retry_ok_s) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else if (piul1I2cAck) begin
            req_r <= 1'b0;
            if (index_r == LAST_IDX) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              index_r <= index_r + 3'd1;
              state_r <= ST_GAP;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            req_r   <= 1'b0;
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_ERROR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign poul1Busy       = busy_r;
  assign poul1Done       = done_r;
  assign poul1Error      = error_r;
  assign poul3Index      = index_r;
  assign poul1I2cReq     = req_r;
  assign poul8I2cDevAddr = dev_addr_r;
  assign poul8I2cRegAddr = reg_addr_r;
  assign poul16I2cData   = data_r;

endmodule

// File: tb/tb_d5m_config_sequencer.sv
// Self-checking bench for d5m_config_sequencer: randomized I2C responder checked against a
// transaction-level model of the table walk; follows D5M_CFG_RETRY_EN if defined.
module tb_d5m_config_sequencer;

  localparam int         GAP   = 4;
  localparam int         TMO   = 20;
  localparam logic [7:0] DEV   = 8'hBA;
  localparam int         LIMIT = 3000;

  localparam int RSP_ACK  = 0;
  localparam int RSP_NACK = 1;
  localparam int RSP_BOTH = 2;
  localparam int RSP_NONE = 3;

`ifdef D5M_CFG_RETRY_EN
  localparam int MAX_RETRY = 3;
`else
  localparam int MAX_RETRY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] exposure = 16'h0000;
  logic        busy, done, error, req;
  logic [2:0]  index;
  logic [7:0]  dev_addr, reg_addr;
  logic [15:0] data;
  logic        ack = 1'b0;
  logic        nack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int plan[$];
  int exp_att[$];
  int exp_idx;
  int exp_done;
  int exp_err;

  always #5 clk = ~clk;

  d5m_config_sequencer #(.GAP_CC(GAP), .TIMEOUT_CC(TMO), .DEV_ADDR(DEV)) dut (
    .piul1Clock      (clk),
    .piul1Reset      (rst),
    .piul1Start      (start),
    .piul16Exposure  (exposure),
    .poul1Busy       (busy),
    .poul1Done       (done),
    .poul1Error      (error),
    .poul3Index      (index),
    .poul1I2cReq     (req),
    .poul8I2cDevAddr (dev_addr),
    .poul8I2cRegAddr (reg_addr),
    .poul16I2cData   (data),
    .piul1I2cAck     (ack),
    .piul1I2cNack    (nack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] entry(input int i, input logic [15:0] e);
    case (i)
      0: entry = {8'h0D, 16'h0001};
      1: entry = {8'h0D, 16'h0000};
      2: entry = {8'h20, 16'hC000};
      3: entry = {8'h09, e};
      4: entry = {8'h05, 16'h0000};
      5: entry = {8'h06, 16'h0019};
      default: entry = 24'h000000;
    endcase
  endfunction

  // Walk the table one attempt at a time using the planned responses (unplanned = ACK).
  task automatic build_model();
    int idx, retries, k, code;
    idx = 0; retries = 0; k = 0;
    exp_att.delete();
    exp_done = 0;
    exp_err = 0;
    while (exp_done == 0 && exp_err == 0) begin
      exp_att.push_back(idx);
      code = (k < plan.size()) ? plan[k] : RSP_ACK;
      k++;
      if (code == RSP_ACK) begin
        if (idx == 5) exp_done = 1;
        else begin idx++; retries = 0; end
      end else if (code == RSP_NONE) begin
        exp_err = 1;
      end else if (retries < MAX_RETRY) begin
        retries++;
      end else begin
        exp_err = 1;
      end
    end
    exp_idx = idx;
  endtask

  task automatic run_seq(input logic [15:0] expo, input int poke_idx);
    int code, low, hi, dly, cyc;
    bit prev, poked, poke_chk;
    logic [23:0] hold;
    int rsp[$];
    int obs_i[$];
    logic [23:0] obs_f[$];
    logic [7:0] obs_d[$];
    build_model();
    rsp = plan;
    exposure = expo;
    low = 0; hi = 0; dly = 1; cyc = 0; code = RSP_ACK;
    prev = 1'b0; poked = 1'b0; poke_chk = 1'b0; hold = 24'h0;
    start = 1'b1;
    while (cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      ack = 1'b0;
      nack = 1'b0;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (poke_chk) begin
        check("start_while_busy_index", index, poke_idx);
        check("start_while_busy_busy", busy, 1);
        poke_chk = 1'b0;
      end
      if (req) begin
        if (!prev) begin
          check("gap_len", low, GAP);
          obs_i.push_back(int'(index));
          obs_f.push_back({reg_addr, data});
          obs_d.push_back(dev_addr);
          hold = {reg_addr, data};
          code = (rsp.size() > 0) ? rsp.pop_front() : RSP_ACK;
          dly = $urandom_range(1, 4);
          hi = 0;
          low = 0;
        end else begin
          check("fields_stable", {reg_addr, data}, hold);
        end
        hi++;
        if (code != RSP_NONE && hi == dly + 1) begin
          ack  = (code == RSP_ACK || code == RSP_BOTH);
          nack = (code == RSP_NACK || code == RSP_BOTH);
        end
      end else begin
        if (prev) check("req_high_len", hi, (code == RSP_NONE) ? TMO + 1 : dly + 1);
        low++;
        if (busy) begin
          if (poke_idx >= 0 && !poked && int'(index) == poke_idx) begin
            start = 1'b1;
            poked = 1'b1;
            poke_chk = 1'b1;
          end else if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) ack = 1'b1;
            else nack = 1'b1;
          end
        end
      end
      prev = req;
      if (!busy) break;
    end
    check("run_bounded", (cyc < LIMIT), 1);
    check("attempt_count", obs_i.size(), exp_att.size());
    for (int i = 0; i < exp_att.size() && i < obs_i.size(); i++) begin
      check("att_index", obs_i[i], exp_att[i]);
      check("att_reg_data", obs_f[i], entry(exp_att[i], expo));
      check("att_dev_addr", obs_d[i], DEV);
    end
    check("final_done", done, exp_done);
    check("final_error", error, exp_err);
    check("final_index", index, exp_idx);
    check("final_busy", busy, 0);
    // Stray responses after the sequence must not restart anything.
    repeat (6) begin
      @(negedge clk);
      ack  = 1'($urandom_range(0, 1));
      nack = 1'($urandom_range(0, 1));
      check("idle_req", req, 0);
    end
    @(negedge clk);
    ack = 1'b0;
    nack = 1'b0;
    check("idle_index_hold", index, exp_idx);
    check("idle_flags_hold", {done, error}, {exp_done[0], exp_err[0]});
  endtask

  initial begin
    bit found;
    bit prevr;
    int n;

    // Reset values, then IDLE must hold without a start.
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index", index, 0);
    check("rst_dev", dev_addr, 0);
    check("rst_reg", reg_addr, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      ack = 1'b1;
      check("idle_after_reset", {busy, req, done, error}, 0);
    end
    ack = 1'b0;

    // Nominal sequence.
    plan.delete();
    run_seq(16'h0797, -1);

    // NACK at entry 2 three times, then ACK.
    plan = '{RSP_ACK, RSP_ACK, RSP_NACK, RSP_NACK, RSP_NACK, RSP_ACK};
    run_seq(16'(($urandom)), -1);

    // No response at entry 0.
    plan = '{RSP_NONE};
    run_seq(16'h0797, -1);

    // Simultaneous ACK and NACK at entry 1.
    plan = '{RSP_ACK, RSP_BOTH};
    run_seq(16'h1111, -1);

    // Start pulse while busy at entry 4.
    plan.delete();
    run_seq(16'(($urandom)), 4);

    // Randomized response plans.
    repeat (5) begin
      plan.delete();
      n = $urandom_range(0, 9);
      repeat (n) plan.push_back(($urandom_range(0, 11) == 0) ? RSP_NONE : int'($urandom_range(0, 2)));
      run_seq(16'(($urandom)), -1);
    end

    // Reset while Req is high at entry 3.
    exposure = 16'h1234;
    found = 1'b0;
    prevr = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      ack = 1'b0;
      if (req && index == 3'd3) found = 1'b1;
      else if (req && prevr) ack = 1'b1;
      prevr = req;
    end
    check("reached_entry3", found, 1);
    rst = 1'b1;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_index", index, 0);
    check("async_rst_fields", {dev_addr, reg_addr, data}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle", {busy, req}, 0);
    plan.delete();
    run_seq(16'(($urandom)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
